// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier family.
// Holds the control FSM state encoding, the operand width and the iteration counter width.
package mult_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/kogge_stone.sv
// 8-bit Kogge-Stone parallel-prefix adder: sum = x + y + cin, with carry-out.
// Three radix-2 prefix levels (spans 1, 2, 4) build the group generate/propagate terms.
module kogge_stone
    import mult_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LEVELS = 3;

    logic [WIDTH-1:0] g [0:LEVELS];
    logic [WIDTH-1:0] p [0:LEVELS];
    logic [WIDTH:0]   carry;

    assign g[0] = x & y;
    assign p[0] = x ^ y;

    // Level k combines each bit with the group 2**k positions below it.
    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= (1 << k)) begin : g_merge
                assign g[k+1][i] = g[k][i] | (p[k][i] & g[k][i-(1<<k)]);
                assign p[k+1][i] = p[k][i] & p[k][i-(1<<k)];
            end else begin : g_pass
                assign g[k+1][i] = g[k][i];
                assign p[k+1][i] = p[k][i];
            end
        end
    end

    assign carry[0]       = cin;
    assign carry[WIDTH:1] = g[LEVELS] | (p[LEVELS] & {WIDTH{cin}});

    assign sum  = p[0] ^ carry[WIDTH-1:0];
    assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_mult8.sv
// Sequential 8x8 unsigned shift-and-add multiplier, one partial product per clock through one prefix adder.
// Optional build macro MULT_ZERO_SKIP_EN sends zero-operand requests straight to DONE.
module shift_add_mult8 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    import mult_pkg::*;

    if (WIDTH != mult_pkg::WIDTH) begin : g_width_check
        $error("shift_add_mult8 only supports WIDTH = 8 (the adder is fixed at 8 bits)");
    end

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   m;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] product_r;

    logic [WIDTH-1:0]   add_y;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH-1:0]   acc_shift;
    logic [WIDTH-1:0]   q_shift;
    logic               zero_skip;
    logic               last_iter;

`ifdef MULT_ZERO_SKIP_EN
    assign zero_skip = (a == '0) || (b == '0);
`else
    assign zero_skip = 1'b0;
`endif

    assign add_y = m & {WIDTH{q[0]}};

    kogge_stone u_adder (
        .x    (acc),
        .y    (add_y),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // {C, ACC, Q} <= {0, cout, sum, Q} >> 1; the carry bit always lands as 0, so it needs no flop.
    assign acc_shift = {add_cout, add_sum[WIDTH-1:1]};
    assign q_shift   = {add_sum[0], q[WIDTH-1:1]};
    assign last_iter = &cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = zero_skip ? DONE : CALC;
            CALC: if (last_iter) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The product is registered separately so it stays put while ACC/Q churn during CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            q         <= '0;
            m         <= '0;
            cnt       <= '0;
            product_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc <= '0;
                        q   <= zero_skip ? '0 : b;
                        m   <= a;
                        cnt <= '0;
                        if (zero_skip) begin
                            product_r <= '0;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_shift;
                    q   <= q_shift;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        product_r <= {acc_shift, q_shift};
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC);
    assign product   = product_r;

endmodule

// File: tb/tb_shift_add_mult8.sv
// Directed self-checking bench for shift_add_mult8: latency, carry path, back-pressure, reset, streaming.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_shift_add_mult8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    shift_add_mult8 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish (observed=timeout required=finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Launch one operation, scramble the operands after acceptance, then measure latency to out_valid.
    task automatic applyStimulus(input logic [7:0] a_v, input logic [7:0] b_v,
                                 input logic [15:0] exp_prod, input int exp_lat, input string tag);
        int lat;
        int busy_cnt;
        logic ready_seen;
        @(negedge clk);
        in_valid = 1'b1;
        a        = a_v;
        b        = b_v;
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        a          = ~a_v;
        b          = ~b_v;
        lat        = 0;
        busy_cnt   = 0;
        ready_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_cnt++;
            if (in_ready) ready_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_busy_cycles"}, busy_cnt, exp_lat);
        checkOutput({tag, "_ready_while_busy"}, {31'd0, ready_seen}, 32'd0);
        checkOutput({tag, "_ready_in_done"}, {31'd0, in_ready}, 32'd0);
        checkOutput({tag, "_product"}, {15'd0, out_valid, product}, {15'd0, 1'b1, exp_prod});
    endtask

    initial begin
        logic [7:0] pa;
        logic [7:0] pb;
        logic [15:0] exp_b2b;
        int last_acc;
        int acc_cyc;
        int w;
        int zero_lat;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 8'h00;
        b         = 8'h00;
        #12;
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_product", {16'd0, product}, 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8'h0D, 8'h0B, 16'h008F, 8, "basic");
        applyStimulus(8'hFF, 8'hFF, 16'hFE01, 8, "carry");

        // Hold the consumer off for five cycles while a fresh request is offered and must be ignored.
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(8'h80, 8'h02, 16'h0100, 8, "bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = 8'h11;
            b        = 8'h11;
            @(negedge clk);
            checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_hold_product", {16'd0, product}, 32'h0100);
            checkOutput("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("bp_release_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("bp_ignored_busy", {31'd0, busy}, 32'd0);

`ifdef MULT_ZERO_SKIP_EN
        zero_lat = 0;
`else
        zero_lat = 8;
`endif
        applyStimulus(8'h00, 8'h5A, 16'h0000, zero_lat, "zero");

        // Abort an operation three cycles into CALC.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'h37;
        b        = 8'h29;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midrst_product", {16'd0, product}, 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h37, 8'h29, 16'h08CF, 8, "rst_redo");

        // Streaming: in_valid stays high and a new pair is presented right after each acceptance.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        pa        = 8'($urandom);
        pb        = 8'($urandom);
        a         = pa;
        b         = pb;
        last_acc  = 0;
        for (int i = 0; i < 1000; i++) begin
            w = 0;
            while (!in_ready && w < 30) begin
                @(negedge clk);
                w++;
            end
            acc_cyc = cyc;
            exp_b2b = 16'(pa) * 16'(pb);
            if (i > 0) checkOutput("b2b_gap", acc_cyc - last_acc, 10);
            last_acc = acc_cyc;
            @(posedge clk);
            @(negedge clk);
            pa = 8'($urandom);
            pb = 8'($urandom);
            a  = pa;
            b  = pb;
            w  = 0;
            while (!out_valid && w < 30) begin
                @(negedge clk);
                w++;
            end
            checkOutput("b2b_product", {15'd0, out_valid, product}, {15'd0, 1'b1, exp_b2b});
        end
        in_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
